// File: rtl/clock_divider_bank.sv
// Bank of independent programmable clock dividers, each run-time loadable with a
// divide value and an output mode (square-wave toggle or one-cycle pulse).
module clock_divider_bank #(
  parameter int                CHANNELS    = 4,
  parameter int                WIDTH       = 24,
  parameter logic [WIDTH-1:0]  DEFAULT_DIV = {WIDTH{1'b1}},
  localparam int               CHW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                en_i,
  input  logic                load_valid_i,
  output logic                load_ready_o,
  input  logic [CHW-1:0]      load_ch_i,
  input  logic [WIDTH-1:0]    load_div_i,
  input  logic                load_mode_i,
  output logic [CHANNELS-1:0] slow_o,
  output logic                load_err_o
);

  localparam int unsigned NumCh = CHANNELS;

  logic                busyQ;
  logic                errQ;
  logic [WIDTH-1:0]    countQ [CHANNELS];
  logic [WIDTH-1:0]    countD [CHANNELS];
  logic [WIDTH-1:0]    divQ   [CHANNELS];
  logic [WIDTH-1:0]    divD   [CHANNELS];
  logic [CHANNELS-1:0] modeQ, modeD;
  logic [CHANNELS-1:0] slowQ, slowD;
  logic                loadFire;
  logic                chInRange;

  // Ready drops for the single cycle after each accepted load, and during reset.
  assign load_ready_o = ~busyQ & ~reset_i;
  assign loadFire     = load_valid_i & load_ready_o;
  assign chInRange    = 32'(load_ch_i) < NumCh;
  assign slow_o       = slowQ;
  assign load_err_o   = errQ;

  // A load to a channel overrides its terminal event on the same edge.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      countD[i] = countQ[i];
      divD[i]   = divQ[i];
      modeD[i]  = modeQ[i];
      slowD[i]  = slowQ[i];
      if (loadFire && chInRange && (load_ch_i == CHW'(i))) begin
        countD[i] = '0;
        divD[i]   = load_div_i;
        modeD[i]  = load_mode_i;
        slowD[i]  = 1'b0;
      end else if (en_i) begin
        if (countQ[i] == divQ[i]) begin
          countD[i] = '0;
          slowD[i]  = modeQ[i] ? 1'b1 : ~slowQ[i];
        end else begin
          countD[i] = countQ[i] + WIDTH'(1);
          slowD[i]  = modeQ[i] ? 1'b0 : slowQ[i];
        end
      end else if (modeQ[i]) begin
        slowD[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      busyQ <= 1'b0;
      errQ  <= 1'b0;
      modeQ <= '0;
      slowQ <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        countQ[i] <= '0;
        divQ[i]   <= DEFAULT_DIV;
      end
    end else begin
      busyQ  <= loadFire;
      errQ   <= loadFire & ~chInRange;
      modeQ  <= modeD;
      slowQ  <= slowD;
      countQ <= countD;
      divQ   <= divD;
    end
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank: five 4-bit channels so that channel
// index 5 is encodable and out of range.
module tb_clock_divider_bank;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       loadValid = 1'b0;
  logic       loadReady;
  logic [2:0] loadCh = '0;
  logic [3:0] loadDiv = '0;
  logic       loadMode = 1'b0;
  logic [4:0] slow;
  logic       loadErr;

  int checks = 0;
  int errors = 0;

  clock_divider_bank #(.CHANNELS(5), .WIDTH(4)) dut (
    .clock_i      (clock),
    .reset_i      (reset),
    .en_i         (en),
    .load_valid_i (loadValid),
    .load_ready_o (loadReady),
    .load_ch_i    (loadCh),
    .load_div_i   (loadDiv),
    .load_mode_i  (loadMode),
    .slow_o       (slow),
    .load_err_o   (loadErr)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic doReset();
    reset = 1'b1;
    en = 1'b0;
    loadValid = 1'b0;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic driveLoad(input logic [2:0] ch, input logic [3:0] dv, input logic md);
    loadValid = 1'b1;
    loadCh = ch;
    loadDiv = dv;
    loadMode = md;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++; if (slow !== 5'b0) begin errors++; $display("[TB] FAIL reset_slow got %b want %b", slow, 5'b0); end
    checks++; if (loadReady !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b want 0", loadReady); end
    checks++; if (loadErr !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", loadErr); end
    tick(1);
    reset = 1'b0;
    #1;
    checks++; if (loadReady !== 1'b1) begin errors++; $display("[TB] FAIL release_ready got %b want 1", loadReady); end
    tick(1);
  endtask

  task automatic test_default_divide();
    doReset();
    en = 1'b1;
    tick(15);
    checks++; if (slow !== 5'b00000) begin errors++; $display("[TB] FAIL default_e15 got %b want %b", slow, 5'b00000); end
    tick(1);
    checks++; if (slow !== 5'b11111) begin errors++; $display("[TB] FAIL default_e16 got %b want %b", slow, 5'b11111); end
    tick(15);
    checks++; if (slow !== 5'b11111) begin errors++; $display("[TB] FAIL default_e31 got %b want %b", slow, 5'b11111); end
    tick(1);
    checks++; if (slow !== 5'b00000) begin errors++; $display("[TB] FAIL default_e32 got %b want %b", slow, 5'b00000); end
  endtask

  task automatic test_pulse();
    logic [4:0] exp;
    doReset();
    en = 1'b1;
    driveLoad(3'd1, 4'd3, 1'b1);
    tick(1);
    loadValid = 1'b0;
    checks++; if (loadReady !== 1'b0) begin errors++; $display("[TB] FAIL pulse_ready got %b want 0", loadReady); end
    for (int n = 2; n <= 17; n++) begin
      tick(1);
      exp = (n >= 16) ? 5'b11101 : 5'b00000;
      exp[1] = (n >= 5) && (n % 4 == 1);
      checks++; if (slow !== exp) begin errors++; $display("[TB] FAIL pulse_e%0d got %b want %b", n, slow, exp); end
    end
  endtask

  task automatic test_handshake();
    doReset();
    driveLoad(3'd2, 4'd1, 1'b0);
    tick(1);
    checks++; if (loadReady !== 1'b0) begin errors++; $display("[TB] FAIL hs_ready1 got %b want 0", loadReady); end
    driveLoad(3'd3, 4'd0, 1'b1);
    tick(1);
    checks++; if (loadReady !== 1'b1) begin errors++; $display("[TB] FAIL hs_ready2 got %b want 1", loadReady); end
    driveLoad(3'd4, 4'd0, 1'b1);
    tick(1);
    checks++; if (loadReady !== 1'b0) begin errors++; $display("[TB] FAIL hs_ready3 got %b want 0", loadReady); end
    loadValid = 1'b0;
    en = 1'b1;
    tick(1);
    checks++; if (slow !== 5'b10000) begin errors++; $display("[TB] FAIL hs_e4 got %b want %b", slow, 5'b10000); end
    tick(1);
    checks++; if (slow !== 5'b10100) begin errors++; $display("[TB] FAIL hs_e5 got %b want %b", slow, 5'b10100); end
    tick(2);
    checks++; if (slow !== 5'b10000) begin errors++; $display("[TB] FAIL hs_e7 got %b want %b", slow, 5'b10000); end
  endtask

  task automatic test_div_zero();
    logic [4:0] exp;
    doReset();
    driveLoad(3'd0, 4'd0, 1'b0);
    tick(1);
    loadValid = 1'b0;
    tick(1);
    driveLoad(3'd1, 4'd0, 1'b1);
    tick(1);
    loadValid = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      exp = (k % 2 == 0) ? 5'b00011 : 5'b00010;
      checks++; if (slow !== exp) begin errors++; $display("[TB] FAIL div0_k%0d got %b want %b", k, slow, exp); end
    end
  endtask

  task automatic test_load_err();
    doReset();
    driveLoad(3'd5, 4'd0, 1'b1);
    tick(1);
    loadValid = 1'b0;
    checks++; if (loadErr !== 1'b1) begin errors++; $display("[TB] FAIL err_set got %b want 1", loadErr); end
    checks++; if (slow !== 5'b0) begin errors++; $display("[TB] FAIL err_slow got %b want %b", slow, 5'b0); end
    tick(1);
    checks++; if (loadErr !== 1'b0) begin errors++; $display("[TB] FAIL err_clear got %b want 0", loadErr); end
    checks++; if (loadReady !== 1'b1) begin errors++; $display("[TB] FAIL err_ready got %b want 1", loadReady); end
    en = 1'b1;
    tick(15);
    checks++; if (slow !== 5'b00000) begin errors++; $display("[TB] FAIL err_e15 got %b want %b", slow, 5'b00000); end
    tick(1);
    checks++; if (slow !== 5'b11111) begin errors++; $display("[TB] FAIL err_e16 got %b want %b", slow, 5'b11111); end
  endtask

  task automatic test_freeze();
    doReset();
    en = 1'b1;
    driveLoad(3'd1, 4'd0, 1'b1);
    tick(1);
    loadValid = 1'b0;
    tick(19);
    checks++; if (slow !== 5'b11111) begin errors++; $display("[TB] FAIL frz_run got %b want %b", slow, 5'b11111); end
    en = 1'b0;
    tick(1);
    checks++; if (slow !== 5'b11101) begin errors++; $display("[TB] FAIL frz_f1 got %b want %b", slow, 5'b11101); end
    tick(6);
    checks++; if (slow !== 5'b11101) begin errors++; $display("[TB] FAIL frz_f7 got %b want %b", slow, 5'b11101); end
    en = 1'b1;
    tick(11);
    checks++; if (slow !== 5'b11111) begin errors++; $display("[TB] FAIL frz_r11 got %b want %b", slow, 5'b11111); end
    tick(1);
    checks++; if (slow !== 5'b00010) begin errors++; $display("[TB] FAIL frz_r12 got %b want %b", slow, 5'b00010); end
  endtask

  task automatic test_collision();
    doReset();
    en = 1'b1;
    tick(15);
    driveLoad(3'd0, 4'd3, 1'b0);
    tick(1);
    loadValid = 1'b0;
    checks++; if (slow !== 5'b11110) begin errors++; $display("[TB] FAIL col_e16 got %b want %b", slow, 5'b11110); end
    tick(3);
    checks++; if (slow !== 5'b11110) begin errors++; $display("[TB] FAIL col_e19 got %b want %b", slow, 5'b11110); end
    tick(1);
    checks++; if (slow !== 5'b11111) begin errors++; $display("[TB] FAIL col_e20 got %b want %b", slow, 5'b11111); end
  endtask

  task automatic test_async_reset();
    doReset();
    en = 1'b1;
    tick(17);
    checks++; if (slow !== 5'b11111) begin errors++; $display("[TB] FAIL ar_pre got %b want %b", slow, 5'b11111); end
    driveLoad(3'd0, 4'd0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (slow !== 5'b0) begin errors++; $display("[TB] FAIL ar_slow got %b want %b", slow, 5'b0); end
    checks++; if (loadReady !== 1'b0) begin errors++; $display("[TB] FAIL ar_ready got %b want 0", loadReady); end
    @(negedge clock);
    loadValid = 1'b0;
    reset = 1'b0;
    tick(15);
    checks++; if (slow !== 5'b00000) begin errors++; $display("[TB] FAIL ar_e15 got %b want %b", slow, 5'b00000); end
    tick(1);
    checks++; if (slow !== 5'b11111) begin errors++; $display("[TB] FAIL ar_e16 got %b want %b", slow, 5'b11111); end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_default_divide();
    test_pulse();
    test_handshake();
    test_div_zero();
    test_load_err();
    test_freeze();
    test_collision();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
